// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
package addsub_pkg;
  typedef enum logic {ADD = 1'b0, SUB = 1'b1} op_e;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  function automatic bit stages_ok(input int width, input int stages);
    return (stages > 0) && (width % stages == 0);
  endfunction
endpackage

// File: rtl/pipe_addsub_if.sv
// Valid/ready operation and result channels of pipe_addsub.
interface pipe_addsub_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/addsub_stage.sv
// One CHUNK-wide registered slice of the carry pipeline; holds when its advance is low.
module addsub_stage #(
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             vld_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic             vld_o,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);
  logic             vld_d, vld_q;
  logic             cout_d, cout_q;
  logic [CHUNK-1:0] sum_d, sum_q;

  always_comb begin
    vld_d  = vld_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    if (adv_i) begin
      vld_d           = vld_i;
      {cout_d, sum_d} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign vld_o  = vld_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
endmodule

// File: rtl/pipe_addsub.sv
// Carry-pipelined WIDTH-bit add/sub: STAGES chunk slices, skewed operands, deskewed results,
// valid/ready flow control with a combinational ready chain from out_ready.
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic          clk,
  input logic          rst_n,
  pipe_addsub_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  if (!stages_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipe_addsub: WIDTH must be a non-zero multiple of STAGES");
  end

  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [STAGES-1:0] vld, adv;

  // Subtract is a + ~b + ~cin, so the borrow-in inverts together with b.
  assign op      = op_e'(bus.in_sub);
  assign b_eff   = (op == SUB) ? ~bus.in_b : bus.in_b;
  assign cin_eff = (op == SUB) ? ~bus.in_cin : bus.in_cin;

  always_comb begin
    adv             = '0;
    adv[STAGES-1]   = !vld[STAGES-1] || bus.out_ready;
    for (int k = STAGES - 2; k >= 0; k--) adv[k] = !vld[k] || adv[k+1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int OPW = WIDTH - k * CHUNK;
    logic [OPW-1:0]           a_src, b_src;
    logic                     cin, vin, cout;
    logic [CHUNK-1:0]         sum;
    logic [(k+1)*CHUNK-1:0]   res;

    if (k == 0) begin : g_head
      assign a_src = bus.in_a;
      assign b_src = b_eff;
      assign cin   = cin_eff;
      assign vin   = bus.in_valid;
      assign res   = sum;
    end else begin : g_body
      // Operands ride with the op held in stage k-1; finished chunks ride alongside stage k.
      logic [OPW-1:0]     a_sk_d, a_sk_q, b_sk_d, b_sk_q;
      logic [k*CHUNK-1:0] lo_d, lo_q;

      always_comb begin
        a_sk_d = a_sk_q;
        b_sk_d = b_sk_q;
        lo_d   = lo_q;
        if (adv[k-1]) begin
          a_sk_d = g_st[k-1].a_src[OPW+CHUNK-1:CHUNK];
          b_sk_d = g_st[k-1].b_src[OPW+CHUNK-1:CHUNK];
        end
        if (adv[k]) lo_d = g_st[k-1].res;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_sk_q <= '0;
          b_sk_q <= '0;
          lo_q   <= '0;
        end else begin
          a_sk_q <= a_sk_d;
          b_sk_q <= b_sk_d;
          lo_q   <= lo_d;
        end
      end

      assign a_src = a_sk_q;
      assign b_src = b_sk_q;
      assign cin   = g_st[k-1].cout;
      assign vin   = vld[k-1];
      assign res   = {sum, lo_q};
    end

    addsub_stage #(.CHUNK(CHUNK)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv_i  (adv[k]),
      .vld_i  (vin),
      .a_i    (a_src[CHUNK-1:0]),
      .b_i    (b_src[CHUNK-1:0]),
      .cin_i  (cin),
      .vld_o  (vld[k]),
      .sum_o  (sum),
      .cout_o (cout)
    );
  end

  // Operand sign bits captured alongside the top chunk for the overflow flag.
  logic             a_msb_d, a_msb_q, b_msb_d, b_msb_q;
  logic [WIDTH-1:0] sum_out;
  flags_t           flg;

  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    if (adv[STAGES-1]) begin
      a_msb_d = g_st[STAGES-1].a_src[CHUNK-1];
      b_msb_d = g_st[STAGES-1].b_src[CHUNK-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
    end
  end

  assign sum_out = g_st[STAGES-1].res;

  always_comb begin
    flg.cout = g_st[STAGES-1].cout;
    flg.ovf  = (a_msb_q == b_msb_q) && (sum_out[WIDTH-1] != a_msb_q);
    flg.zero = vld[STAGES-1] && (sum_out == '0);
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.out_sum   = sum_out;
  assign bus.out_cout  = flg.cout;
  assign bus.out_ovf   = flg.ovf;
  assign bus.out_zero  = flg.zero;
endmodule
